// File: rtl/clk_div_prog_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Combinational only; no latency or backpressure.
package clk_div_prog_pkg;

  localparam int          DIV_SEL_W   = 3;
  localparam int          MAX_NCH     = 8;
  localparam int unsigned DIV_RST_DEF = 100000000;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_INC,
    ACT_WRAP,
    ACT_APPLY
  } chan_act_e;

  function automatic logic sel_valid(input logic [DIV_SEL_W-1:0] sel, input int nch);
    return (int'(sel) < nch) && (int'(sel) < MAX_NCH);
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the divider: enables, clear, divisor load, ticks and squares.
// Plain wires; no latency or backpressure of its own.
interface clk_div_prog_if
  import clk_div_prog_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 27
) ();

  logic [NCH-1:0]       en;
  logic                 sync_clr;
  logic                 div_load;
  logic [DIV_SEL_W-1:0] div_sel;
  logic [CNT_W-1:0]     div_in;
  logic [NCH-1:0]       div_busy;
  logic                 load_err;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       sq;

  modport master (
    output en, sync_clr, div_load, div_sel, div_in,
    input  div_busy, load_err, tick, sq
  );

  modport slave (
    input  en, sync_clr, div_load, div_sel, div_in,
    output div_busy, load_err, tick, sq
  );

endinterface

// File: rtl/clk_div_prog_chan.sv
// One divider channel: counter, active/staged divisor, tick and square (cnt_out with CLK_DIV_CNT_OUT_EN).
// Tick registered one cycle after terminal count; no backpressure, loads always accepted.
module clk_div_prog_chan
  import clk_div_prog_pkg::*;
#(
  parameter int          CNT_W   = 27,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
`ifdef CLK_DIV_CNT_OUT_EN
  output logic [CNT_W-1:0] cnt_out,
`endif
  output logic             busy,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pend;
  chan_act_e        act;
  logic             apply;

  always_comb begin
    act = ACT_HOLD;
    if (sync_clr)
      act = ACT_CLR;
    else if (en)
      act = (cnt == div_reg - ONE) ? ACT_WRAP : ACT_INC;
    else if (busy)
      act = ACT_APPLY;
  end

  // A staged divisor only takes over at a period boundary: clear, terminal or idle edge.
  assign apply = busy && (act != ACT_INC) && (act != ACT_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_reg <= CNT_W'(DIV_RST);
      pend    <= '0;
      busy    <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (act)
        ACT_CLR: begin
          cnt <= '0;
          sq  <= 1'b0;
        end
        ACT_WRAP: begin
          cnt  <= '0;
          tick <= 1'b1;
          sq   <= ~sq;
        end
        ACT_INC:   cnt <= cnt + ONE;
        ACT_APPLY: cnt <= '0;
        default:   ;
      endcase
      if (apply)
        div_reg <= pend;
      // A new load wins over the clear of busy, so it is staged for the next boundary.
      if (load) begin
        pend <= load_val;
        busy <= 1'b1;
      end else if (apply) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_CNT_OUT_EN
  assign cnt_out = cnt;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable divider: load decode/validation, load_err pulse, NCH channels (cnt_out with CLK_DIV_CNT_OUT_EN).
// load_err one cycle after a rejected load; ticks one cycle after terminal; no backpressure.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          CNT_W   = 27,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CLK_DIV_CNT_OUT_EN
  output logic [NCH*CNT_W-1:0] cnt_out,
`endif
  clk_div_prog_if.slave        bus
);

  logic           ld_ok;
  logic           load_err_q;
  logic [NCH-1:0] busy_v;
  logic [NCH-1:0] tick_v;
  logic [NCH-1:0] sq_v;

  assign ld_ok = bus.div_load && sel_valid(bus.div_sel, NCH) && (bus.div_in != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      load_err_q <= 1'b0;
    else
      load_err_q <= bus.div_load && !ld_ok;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_prog_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en[i]),
      .sync_clr (bus.sync_clr),
      .load     (ld_ok && (bus.div_sel == DIV_SEL_W'(i))),
      .load_val (bus.div_in),
`ifdef CLK_DIV_CNT_OUT_EN
      .cnt_out  (cnt_out[i*CNT_W +: CNT_W]),
`endif
      .busy     (busy_v[i]),
      .tick     (tick_v[i]),
      .sq       (sq_v[i])
    );
  end

  assign bus.div_busy = busy_v;
  assign bus.tick     = tick_v;
  assign bus.sq       = sq_v;
  assign bus.load_err = load_err_q;

endmodule
